// File: rtl/fpu_pkg.sv
// Shared single-precision definitions for the iterative FP divider.
// Holds the IEEE-754 single field layout, exponent constants, the canonical
// quiet NaN and the divider FSM state encoding.
package fpu_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } float_t;

    localparam int unsigned EXP_BIAS = 127;
    localparam int unsigned EXP_MAX  = 255;
    localparam logic [31:0] QNAN     = 32'h7FC00000;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StRound,
        StDone
    } fdiv_state_e;

endpackage

// File: rtl/fdiv_special.sv
// Operand classifier for the FP divider (purely combinational).
// Exponent 0 is treated as zero and exponent 255 as infinity; mantissas are
// ignored, so only sign and exponent fields are needed.
// Ports:
//   a_sign_i, a_exp_i  dividend sign / biased exponent
//   b_sign_i, b_exp_i  divisor sign / biased exponent
//   special_o          result is fully determined by the operand classes
//   result_o           that result (NaN, signed infinity or signed zero)
module fdiv_special
    import fpu_pkg::*;
(
    input  logic        a_sign_i,
    input  logic [7:0]  a_exp_i,
    input  logic        b_sign_i,
    input  logic [7:0]  b_exp_i,
    output logic        special_o,
    output logic [31:0] result_o
);

    logic a_zero, a_inf, b_zero, b_inf, sign;

    assign a_zero = (a_exp_i == 8'd0);
    assign a_inf  = (a_exp_i == 8'(EXP_MAX));
    assign b_zero = (b_exp_i == 8'd0);
    assign b_inf  = (b_exp_i == 8'(EXP_MAX));
    assign sign   = a_sign_i ^ b_sign_i;

    always_comb begin
        special_o = 1'b0;
        result_o  = 32'h0;
        // Order matters: the two indeterminate forms must win over the
        // infinity/zero rules they would otherwise also match.
        if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            special_o = 1'b1;
            result_o  = QNAN;
        end else if (a_inf || b_zero) begin
            special_o = 1'b1;
            result_o  = {sign, 8'hFF, 23'h0};
        end else if (a_zero || b_inf) begin
            special_o = 1'b1;
            result_o  = {sign, 31'h0};
        end
    end

endmodule

// File: rtl/fdiv_iter.sv
// Iterative IEEE-754 single-precision divider, y = x1 / x2.
// Restoring radix-2 division, one quotient bit per cycle for QBITS cycles,
// then a normalize / round-to-nearest-even step. No denormal support:
// exponent 0 reads as zero, exponent 255 as infinity.
// Configuration macro: FDIV_ITER_EARLY_OUT_EN -- when defined, special-case
// operands skip the iteration and produce a result 2 edges after acceptance;
// otherwise every operation takes the full 1+QBITS latency.
// Ports:
//   clk, rstn             clock, asynchronous active-low reset
//   x1, x2                dividend / divisor, sampled when in_valid && in_ready
//   in_valid, in_ready    operand handshake (in_ready high only when idle)
//   y, out_valid          result, held stable until out_ready
//   out_ready             consumer accepts y
module fdiv_iter
    import fpu_pkg::*;
#(
    parameter int unsigned QBITS = 26
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] y,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int unsigned CW = $clog2(QBITS + 1);
    // Quotient bits below the guard position feed the sticky bit.
    localparam logic [QBITS-1:0] LOW_MASK = (QBITS'(1) << (QBITS - 25)) - QBITS'(1);

    fdiv_state_e state_q, state_d;

    logic              a_sign_q, a_sign_d;
    logic [7:0]        a_exp_q,  a_exp_d;
    logic              b_sign_q, b_sign_d;
    logic [7:0]        b_exp_q,  b_exp_d;
    logic [23:0]       mb_q,     mb_d;
    logic [24:0]       rem_q,    rem_d;
    logic [QBITS-1:0]  quo_q,    quo_d;
    logic [CW-1:0]     cnt_q,    cnt_d;
    logic [31:0]       y_q,      y_d;
    logic              out_valid_q, out_valid_d;

    float_t x1_f, x2_f;
    assign x1_f = x1;
    assign x2_f = x2;

    logic        special;
    logic [31:0] special_y;
    logic        skip_calc;

    fdiv_special u_special (
        .a_sign_i  (a_sign_q),
        .a_exp_i   (a_exp_q),
        .b_sign_i  (b_sign_q),
        .b_exp_i   (b_exp_q),
        .special_o (special),
        .result_o  (special_y)
    );

`ifdef FDIV_ITER_EARLY_OUT_EN
    assign skip_calc = special;
`else
    assign skip_calc = 1'b0;
`endif

    // One restoring step: subtract when it fits, then shift the partial
    // remainder. The remainder stays below 2*divisor so 25 bits suffice.
    logic        rem_ge;
    logic [24:0] rem_sel;
    assign rem_ge  = (rem_q >= {1'b0, mb_q});
    assign rem_sel = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;

    // Normalize / round path, evaluated on the finished quotient.
    logic [QBITS-1:0]  quo_norm;
    logic [23:0]       mant_trunc;
    logic              guard, sticky, round_up;
    logic [24:0]       mant_rnd;
    logic signed [10:0] exp_res;
    logic              res_sign;
    logic [31:0]       round_y;

    always_comb begin
        // Mantissa ratio lies in (0.5, 2): the MSB decides whether one extra
        // left shift (and an exponent decrement) is needed.
        quo_norm   = quo_q[QBITS-1] ? quo_q : (quo_q << 1);
        mant_trunc = quo_norm[QBITS-1 -: 24];
        guard      = quo_norm[QBITS-25];
        sticky     = (|(quo_norm & LOW_MASK)) | (|rem_q);
        round_up   = guard & (sticky | mant_trunc[0]);
        mant_rnd   = {1'b0, mant_trunc} + {24'b0, round_up};
        res_sign   = a_sign_q ^ b_sign_q;
        // A rounding carry leaves the fraction field at zero and bumps the exponent.
        exp_res    = $signed({3'b000, a_exp_q}) - $signed({3'b000, b_exp_q})
                   + $signed(11'(EXP_BIAS))
                   - (quo_q[QBITS-1] ? 11'sd0 : 11'sd1)
                   + $signed({10'b0, mant_rnd[24]});
        if (special) begin
            round_y = special_y;
        end else if (exp_res > 11'sd254) begin
            round_y = {res_sign, 8'hFF, 23'h0};
        end else if (exp_res < 11'sd1) begin
            round_y = {res_sign, 31'h0};
        end else begin
            round_y = {res_sign, exp_res[7:0], mant_rnd[22:0]};
        end
    end

    always_comb begin
        state_d     = state_q;
        a_sign_d    = a_sign_q;
        a_exp_d     = a_exp_q;
        b_sign_d    = b_sign_q;
        b_exp_d     = b_exp_q;
        mb_d        = mb_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_sign_d = x1_f.sign;
                    a_exp_d  = x1_f.exp;
                    b_sign_d = x2_f.sign;
                    b_exp_d  = x2_f.exp;
                    mb_d     = {1'b1, x2_f.mant};
                    rem_d    = {2'b01, x1_f.mant};
                    quo_d    = '0;
                    cnt_d    = '0;
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                if (skip_calc) begin
                    state_d = StRound;
                end else begin
                    rem_d = {rem_sel[23:0], 1'b0};
                    quo_d = {quo_q[QBITS-2:0], rem_ge};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(QBITS - 1)) begin
                        state_d = StRound;
                    end
                end
            end
            StRound: begin
                y_d         = round_y;
                out_valid_d = 1'b1;
                state_d     = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            a_sign_q    <= 1'b0;
            a_exp_q     <= 8'h0;
            b_sign_q    <= 1'b0;
            b_exp_q     <= 8'h0;
            mb_q        <= 24'h0;
            rem_q       <= 25'h0;
            quo_q       <= '0;
            cnt_q       <= '0;
            y_q         <= 32'h0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sign_q    <= a_sign_d;
            a_exp_q     <= a_exp_d;
            b_sign_q    <= b_sign_d;
            b_exp_q     <= b_exp_d;
            mb_q        <= mb_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign y         = y_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fdiv_iter.sv
// Directed self-checking bench for fdiv_iter (QBITS = 26).
module tb_fdiv_iter;

    localparam int FULL_LAT = 27;
`ifdef FDIV_ITER_EARLY_OUT_EN
    localparam int SPEC_LAT = 2;
`else
    localparam int SPEC_LAT = 27;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] x1 = 32'h0;
    logic [31:0] x2 = 32'h0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] y;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fdiv_iter #(.QBITS(26)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .x1        (x1),
        .x2        (x2),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    // Present one operand pair, then count edges until out_valid (bounded).
    task automatic issue(input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clk);
        x1 = a;
        x2 = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        x1 = 32'hDEADBEEF;
        x2 = 32'h3F800000;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_y, input int exp_lat);
        int lat;
        check({tag, "_in_ready_before"}, 32'(in_ready), 32'd1);
        issue(a, b, lat);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_y"}, y, exp_y);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_out_valid_cleared"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        logic [31:0] held_y;
        logic seen_valid;

        // Reset state
        #12;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_y", y, 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        // Normal division and rounding
        run_op("div_6_2", 32'h40C00000, 32'h40000000, 32'h40400000, FULL_LAT);
        run_op("div_1_3_rne", 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, FULL_LAT);
        run_op("div_neg6_2", 32'hC0C00000, 32'h40000000, 32'hC0400000, FULL_LAT);

        // Special operands
        run_op("neg1_div_0", 32'hBF800000, 32'h00000000, 32'hFF800000, SPEC_LAT);
        run_op("zero_div_0", 32'h00000000, 32'h00000000, 32'h7FC00000, SPEC_LAT);
        run_op("inf_div_inf", 32'h7F800000, 32'hFF800000, 32'h7FC00000, SPEC_LAT);
        run_op("inf_div_2", 32'h7F800000, 32'h40000000, 32'h7F800000, SPEC_LAT);
        run_op("2_div_neginf", 32'h40000000, 32'hFF800000, 32'h80000000, SPEC_LAT);

        // Exponent range limits
        run_op("overflow", 32'h7F000000, 32'h00800000, 32'h7F800000, FULL_LAT);
        run_op("underflow", 32'h00800000, 32'h7F000000, 32'h00000000, FULL_LAT);

        // Back-pressure: hold out_ready low with a pending request
        issue(32'h40C00000, 32'h40000000, lat);
        check("stall_latency", 32'(lat), 32'(FULL_LAT));
        check("stall_y_first", y, 32'h40400000);
        held_y = 32'h40400000;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x1 = 32'h41200000 + 32'(i);
            x2 = 32'h3F800000;
            @(posedge clk);
            #1;
            check("stall_y_stable", y, held_y);
            check("stall_in_ready_low", 32'(in_ready), 32'd0);
            check("stall_out_valid_high", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        check("stall_release_out_valid", 32'(out_valid), 32'd0);
        check("stall_release_not_accepted", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("stall_still_idle", 32'(in_ready), 32'd1);

        // Reset in the middle of an iteration
        @(negedge clk);
        x1 = 32'h40C00000;
        x2 = 32'h40000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        check("midcalc_busy", 32'(in_ready), 32'd0);
        rstn = 1'b0;
        #1;
        check("midcalc_rst_out_valid", 32'(out_valid), 32'd0);
        check("midcalc_rst_in_ready", 32'(in_ready), 32'd1);
        check("midcalc_rst_y", y, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen_valid = 1'b1;
        end
        check("midcalc_no_stale_result", 32'(seen_valid), 32'd0);
        check("midcalc_idle_after", 32'(in_ready), 32'd1);
        run_op("after_reset_10_5", 32'h41200000, 32'h40A00000, 32'h40000000, FULL_LAT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
